sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM macro (A/DI/DO/WEB/OE/CS, 1-cycle read latency) between NREQ requesters, e.g. the AXI slave wrapper and a DMA/boot-loader port.
- Provides round-robin arbitration, optional locked bursts, and SRAM pin sequencing.
- Returns read data to the requester that issued the read.
- Sits between the SRAM wrapper front-ends and the SRAM instance.

Parameters:
NREQ, 2, number of requesters (2..4)
ADDR_W, 14, SRAM word-address width
DATA_W, 32, data width; STRB_W = DATA_W/8 is derived
MAX_HOLD, 16, maximum consecutive granted cycles under lock (used only with the optional feature)

Ports:
ACLK  in  1  clock; all state updates on its rising edge
ARESETn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester access request; requester i holds req[i]/we/addr/wdata/wstrb/lock slice stable until gnt[i]
we  in  NREQ  1 = write, 0 = read
addr  in  NREQ*ADDR_W  word address; slice i is [i*ADDR_W +: ADDR_W]
wdata  in  NREQ*DATA_W  write data, sliced the same way
wstrb  in  NREQ*STRB_W  byte strobes, active-high
lock  in  NREQ  keep ownership after this access
gnt  out  NREQ  one-hot; the access is performed this cycle
rvalid  out  NREQ  one-hot; read data valid for requester i
rdata  out  DATA_W  read data, shared by all requesters; qualified by rvalid
A  out  ADDR_W  SRAM address
DI  out  DATA_W  SRAM write data
DO  in  DATA_W  SRAM read data, valid the cycle after a read
WEB  out  STRB_W  SRAM byte write enables, active-low
OE  out  1  SRAM output enable
CS  out  1  SRAM chip select

Behaviour:
- Reset, asynchronous on ARESETn=0:
  - gnt=0, rvalid=0, CS=0, OE=0, WEB=all 1, A=0, DI=0.
  - Round-robin pointer ptr=0, state=ARB, owner=0, read tag cleared.
- gnt, A, DI, WEB and CS are combinational from the registered state and the current req inputs, so an access is issued in the same cycle as its grant.
- State ARB:
  - Winner = first i with req[i]=1, searching ptr, ptr+1, … modulo NREQ.
  - gnt[winner]=1, CS=1, A=addr[winner].
  - Write: DI=wdata[winner], WEB=~wstrb[winner]. Read: WEB=all 1.
  - After a grant: ptr <= winner+1 mod NREQ.
  - If lock[winner]=1: owner <= winner, go to LOCK.
  - No req: CS=0, WEB=all 1; ptr is unchanged.
- State LOCK:
  - Only owner may be granted; other requests wait.
  - A grant with lock[owner]=0, or a cycle with req[owner]=0, returns to ARB. On that cycle ptr <= owner+1.
  - An idle cycle in LOCK (req[owner]=0) issues no access.
- Read return:
  - A read granted in cycle t sets the tag (valid, index) at the t edge.
  - In cycle t+1: OE=1, rvalid[index]=1, rdata=DO.
  - Back-to-back reads give rvalid on consecutive cycles. OE=0 and rdata=0 otherwise.
- Writes produce no rvalid. A write with wstrb=0 still consumes the grant and asserts CS with WEB=all 1.
- A write to the address read in the previous cycle does not affect that read's returned data.
- Reset mid-operation: a pending read tag is dropped (no rvalid); a lock is released.

Optional Feature:
- Macro SRAM_ARB_MAXHOLD_EN.
- Defined:
  - A hold counter counts granted cycles in LOCK.
  - When it reaches MAX_HOLD and another req is pending, the lock is forcibly released. The next cycle is in ARB with ptr=owner+1.
  - The counter clears on entry to ARB.
- Undefined: lock is held indefinitely; no counter logic is present.

Test Plan:
- Req0 write addr 0x0010 wdata 0xDEADBEEF wstrb 4'hF, then req1 read 0x0010 → cycle 1: gnt=01, WEB=0, CS=1. Cycle 2: gnt=10, WEB=F. Cycle 3: OE=1, rvalid=10, rdata=0xDEADBEEF.
- req=11 held continuously, lock=0, all reads → gnt alternates 01,10,01,10; rvalid follows the same pattern one cycle later.
- Wstrb=4'b0010 write of 0x11223344 over 0xAAAAAAAA, then read → WEB=4'b1101; read returns 0xAAAA33AA.
- Req0 lock=1 for 4 reads while req1 is pending → gnt=01 four times. req1 is granted in the cycle after req0's grant with lock=0.
- ARESETn pulsed low the cycle after a read grant → rvalid stays 0, CS=0, WEB=F; after release the first grant goes to req0 (ptr=0).
- With SRAM_ARB_MAXHOLD_EN and MAX_HOLD=3: req0 locked indefinitely, req1 pending → three gnt=01, then gnt=10.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port SRAM macro between NREQ requesters. Arbitration is
// round-robin, with optional locked bursts. Read data comes back one cycle
// after the grant and is steered to the requester that issued the read.
//
// Optional feature: define SRAM_ARB_MAXHOLD_EN to bound how long a locked
// owner may keep the SRAM while another requester is waiting. MAX_HOLD sets
// that bound. Without the macro a lock is held for as long as the owner keeps
// asserting it, and MAX_HOLD has no effect.
module sram_port_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  input  logic [NREQ*STRB_W-1:0]   wstrb,
  input  logic [NREQ-1:0]          lock,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        A,
  output logic [DATA_W-1:0]        DI,
  input  logic [DATA_W-1:0]        DO,
  output logic [STRB_W-1:0]        WEB,
  output logic                     OE,
  output logic                     CS
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             rd_valid_q;
  logic [IDX_W-1:0] rd_idx_q;

  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic             issue;
  int               cand;

`ifdef SRAM_ARB_MAXHOLD_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [NREQ-1:0]   others_req;
`endif

  // Next index after i, wrapping at NREQ.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == NREQ - 1) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Pick this cycle's winner: the owner alone while locked, otherwise the
  // first requester found searching from the round-robin pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (state_q == ST_LOCK) begin
      if (req[owner_q]) begin
        grant_any = 1'b1;
        grant_idx = owner_q;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (int'(ptr_q) + k) % NREQ;
        if (!grant_any && req[cand]) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'(cand);
        end
      end
    end
  end

  // A grant is suppressed while reset is held so the SRAM pins stay idle.
  assign issue = grant_any && ARESETn;

  // Drive the grant and the SRAM pins in the same cycle as the grant decision.
  always_comb begin
    gnt = '0;
    CS  = 1'b0;
    A   = '0;
    DI  = '0;
    WEB = '1;
    if (issue) begin
      gnt[grant_idx] = 1'b1;
      CS             = 1'b1;
      A              = addr[grant_idx*ADDR_W +: ADDR_W];
      if (we[grant_idx]) begin
        DI  = wdata[grant_idx*DATA_W +: DATA_W];
        WEB = ~wstrb[grant_idx*STRB_W +: STRB_W];
      end
    end
  end

  // Return read data one cycle after its grant, tagged for the issuing requester.
  always_comb begin
    rvalid = '0;
    OE     = rd_valid_q;
    rdata  = '0;
    if (rd_valid_q) begin
      rvalid[rd_idx_q] = 1'b1;
      rdata            = DO;
    end
  end

  // Next state: ARB grants move the pointer and may start a lock; in LOCK the
  // owner keeps the SRAM until it drops lock or req (or is forced out when the
  // hold bound is enabled), and the pointer then moves past the owner.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
`ifdef SRAM_ARB_MAXHOLD_EN
    hold_d     = hold_q;
    hold_inc   = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    others_req = req;
    others_req[owner_q] = 1'b0;
`endif
    case (state_q)
      ST_ARB: begin
`ifdef SRAM_ARB_MAXHOLD_EN
        hold_d = '0;
`endif
        if (grant_any) begin
          ptr_d = next_idx(grant_idx);
          if (lock[grant_idx]) begin
            state_d = ST_LOCK;
            owner_d = grant_idx;
`ifdef SRAM_ARB_MAXHOLD_EN
            hold_d  = HOLD_W'(1);
`endif
          end
        end
      end
      ST_LOCK: begin
        if (!req[owner_q] || !lock[owner_q]) begin
          state_d = ST_ARB;
          ptr_d   = next_idx(owner_q);
`ifdef SRAM_ARB_MAXHOLD_EN
          hold_d  = '0;
`endif
        end else begin
`ifdef SRAM_ARB_MAXHOLD_EN
          hold_d = hold_inc;
          if ((hold_inc == HOLD_W'(MAX_HOLD)) && (|others_req)) begin
            state_d = ST_ARB;
            ptr_d   = next_idx(owner_q);
            hold_d  = '0;
          end
`endif
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State, pointer, owner and read tag registers; reset drops any pending read.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      rd_valid_q <= issue && !we[grant_idx];
      rd_idx_q   <= grant_idx;
    end
  end

`ifdef SRAM_ARB_MAXHOLD_EN
  // Count granted cycles spent under lock.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter with two requesters and a small
// behavioural SRAM (1-cycle read latency, byte writes). With
// SRAM_ARB_MAXHOLD_EN defined the lock sequence checks the forced release
// at MAX_HOLD=3 instead of an indefinitely held lock.
module tb_sram_port_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic [1:0]  req, we, lock;
  logic [27:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic [3:0]  WEB;
  logic        OE, CS;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [256] = '{default: 32'h0};

  sram_port_arbiter #(
    .NREQ(2), .ADDR_W(14), .DATA_W(32), .MAX_HOLD(3)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .lock(lock), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .A(A), .DI(DI), .DO(DO), .WEB(WEB), .OE(OE), .CS(CS)
  );

  // 10-unit clock period
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Behavioural SRAM: registered read data, active-low byte write enables
  always @(posedge ACLK) begin
    if (CS) begin
      DO <= mem[A[7:0]];
      for (int b = 0; b < 4; b++) begin
        if (!WEB[b]) mem[A[7:0]][b*8 +: 8] <= DI[b*8 +: 8];
      end
    end
  end

  // Single comparison point
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drive one cycle of requester inputs at the falling edge
  task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                                input logic [13:0] a0, input logic [13:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [3:0] s0, input logic [3:0] s1);
    @(negedge ACLK);
    req   = r;
    we    = w;
    lock  = l;
    addr  = {a1, a0};
    wdata = {d1, d0};
    wstrb = {s1, s0};
    #1;
  endtask

  // Compare the grant/pin/read-return outputs for the current cycle
  task automatic check_output(input string tag, input logic [1:0] e_gnt, input logic e_cs,
                              input logic [3:0] e_web, input logic [1:0] e_rvalid,
                              input logic [31:0] e_rdata);
    check({tag, ".gnt"},    64'(gnt),    64'(e_gnt));
    check({tag, ".CS"},     64'(CS),     64'(e_cs));
    check({tag, ".WEB"},    64'(WEB),    64'(e_web));
    check({tag, ".rvalid"}, 64'(rvalid), 64'(e_rvalid));
    check({tag, ".OE"},     64'(OE),     64'(|e_rvalid));
    check({tag, ".rdata"},  64'(rdata),  64'(e_rdata));
  endtask

  initial begin
    ARESETn = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0; wstrb = '0;

    // Reset state
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); #1;
    check_output("reset", 2'b00, 1'b0, 4'hF, 2'b00, 32'h0);
    check("reset.A", 64'(A), 64'h0);
    check("reset.DI", 64'(DI), 64'h0);
    ARESETn = 1'b1;

    // Write from req0, read back through req1
    apply_stimulus(2'b01, 2'b01, 2'b00, 14'h0010, 14'h0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
    check_output("t1c1", 2'b01, 1'b1, 4'h0, 2'b00, 32'h0);
    check("t1c1.A", 64'(A), 64'h10);
    check("t1c1.DI", 64'(DI), 64'hDEADBEEF);
    apply_stimulus(2'b10, 2'b00, 2'b00, 14'h0, 14'h0010, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t1c2", 2'b10, 1'b1, 4'hF, 2'b00, 32'h0);
    check("t1c2.A", 64'(A), 64'h10);
    apply_stimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t1c3", 2'b00, 1'b0, 4'hF, 2'b10, 32'hDEADBEEF);

    // Both requesting reads continuously: alternate grants
    apply_stimulus(2'b11, 2'b00, 2'b00, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t2c1", 2'b01, 1'b1, 4'hF, 2'b00, 32'h0);
    apply_stimulus(2'b11, 2'b00, 2'b00, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t2c2", 2'b10, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b11, 2'b00, 2'b00, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t2c3", 2'b01, 1'b1, 4'hF, 2'b10, 32'h0);
    apply_stimulus(2'b11, 2'b00, 2'b00, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t2c4", 2'b10, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t2c5", 2'b00, 1'b0, 4'hF, 2'b10, 32'h0);

    // Partial byte write over a full word, then read back
    apply_stimulus(2'b01, 2'b01, 2'b00, 14'h0030, 14'h0, 32'hAAAAAAAA, 32'h0, 4'hF, 4'h0);
    check_output("t3c1", 2'b01, 1'b1, 4'h0, 2'b00, 32'h0);
    apply_stimulus(2'b10, 2'b10, 2'b00, 14'h0, 14'h0030, 32'h0, 32'h11223344, 4'h0, 4'b0010);
    check_output("t3c2", 2'b10, 1'b1, 4'b1101, 2'b00, 32'h0);
    check("t3c2.DI", 64'(DI), 64'h11223344);
    apply_stimulus(2'b01, 2'b00, 2'b00, 14'h0030, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t3c3", 2'b01, 1'b1, 4'hF, 2'b00, 32'h0);
    apply_stimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t3c4", 2'b00, 1'b0, 4'hF, 2'b01, 32'hAAAA33AA);

    // Move the pointer to req0, then a locked burst from req0 with req1 waiting
    apply_stimulus(2'b10, 2'b00, 2'b00, 14'h0, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t4c0", 2'b10, 1'b1, 4'hF, 2'b00, 32'h0);
`ifndef SRAM_ARB_MAXHOLD_EN
    apply_stimulus(2'b11, 2'b00, 2'b01, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t4c1", 2'b01, 1'b1, 4'hF, 2'b10, 32'h0);
    apply_stimulus(2'b11, 2'b00, 2'b01, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t4c2", 2'b01, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b11, 2'b00, 2'b01, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t4c3", 2'b01, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b11, 2'b00, 2'b00, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t4c4", 2'b01, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b10, 2'b00, 2'b00, 14'h0, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t4c5", 2'b10, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t4c6", 2'b00, 1'b0, 4'hF, 2'b10, 32'h0);
`else
    apply_stimulus(2'b11, 2'b00, 2'b01, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("mh1", 2'b01, 1'b1, 4'hF, 2'b10, 32'h0);
    apply_stimulus(2'b11, 2'b00, 2'b01, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("mh2", 2'b01, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b11, 2'b00, 2'b01, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("mh3", 2'b01, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b11, 2'b00, 2'b01, 14'h0010, 14'h0020, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("mh4", 2'b10, 1'b1, 4'hF, 2'b01, 32'hDEADBEEF);
    apply_stimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("mh5", 2'b00, 1'b0, 4'hF, 2'b10, 32'h0);
`endif

    // Read grant to req0 (pointer moves to 1), then reset pulsed mid-read
    apply_stimulus(2'b01, 2'b00, 2'b00, 14'h0010, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t5c1", 2'b01, 1'b1, 4'hF, 2'b00, 32'h0);
    @(negedge ACLK);
    ARESETn = 1'b0;
    req     = 2'b11;
    addr    = {14'h0020, 14'h0010};
    #1;
    check_output("t5rst", 2'b00, 1'b0, 4'hF, 2'b00, 32'h0);
    check("t5rst.A", 64'(A), 64'h0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check_output("t5c2", 2'b01, 1'b1, 4'hF, 2'b00, 32'h0);
    apply_stimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check_output("t5c3", 2'b00, 1'b0, 4'hF, 2'b01, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
